int_sequencer: RTL and testbench
================================

Name: int_sequencer

Overview:
- Interrupt controller for the 8-bit core. It latches requests from the timer and up to three external sources, and applies a software mask.
- It picks the highest-priority request and takes over the PC mux at an instruction boundary to jump to a vector. It holds the return address and restores it on return-from-interrupt.
- It sits beside the PC register and the PC-select mux and drives the 10-bit PC path.

Parameters:
- PCW, 10, PC width in bits.
- VEC_BASE, 10'h3C0, address of the vector for source 0.
- VEC_SHIFT, 2, vector spacing as log2 of the stride. Vector for source i = VEC_BASE + (i << VEC_SHIFT), truncated to PCW bits.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  4  request lines. Bit 0 is the timer and has the highest priority; bit 3 has the lowest.
- mask_we  in  1  write enable for the mask register.
- mask_d  in  4  new mask value; 1 = source enabled.
- boundary  in  1  high for the single cycle in which the core loads the next PC.
- pc_next  in  PCW  PC value the core would load this cycle.
- reti  in  1  return-from-interrupt decoded; only meaningful together with boundary.
- pc_override  out  1  when high, the PC mux must load int_pc instead of pc_next.
- int_pc  out  PCW  vector address or return address.
- pending  out  4  latched requests.
- in_service  out  4  one-hot ID of the source being serviced; 0 when idle.
- int_active  out  1  high while in the SERVICE state.

Behaviour:
- Reset (synchronous, active-high; one clock, one reset):
  - pending=0, mask=0, in_service=0, ret_reg=0, irq_q=0, state=IDLE.
  - pc_override=0 and int_pc=0 (combinational, following the cleared state).
  - Reset overrides all other events in the same cycle.
- Edge detection:
  - irq_q <= irq every cycle.
  - pending[i] is set at the clock edge where irq[i]=1 and irq_q[i]=0. A line held high produces exactly one request.
  - Because irq_q resets to 0, a line that is high when reset deasserts registers one request.
  - Requests are latched regardless of the mask.
- Mask: written at the edge where mask_we=1; it affects eligibility from the next cycle.
- eligible = pending & mask, using registered values only. An edge sampled at edge N can be taken at the earliest on a boundary in cycle N+1.
- IDLE:
  - Take condition: boundary=1 and eligible!=0. id = lowest set bit of eligible.
  - While taking, combinationally: pc_override=1 and int_pc=vector(id).
  - At the clock edge: ret_reg <= pc_next, pending[id] <= 0, in_service <= onehot(id), state -> SERVICE.
  - If a new edge on the same source arrives in the same cycle, the set wins and pending[id] stays 1.
  - reti is ignored in IDLE.
- SERVICE:
  - New edges keep accumulating in pending; no preemption.
  - Return condition: reti=1 and boundary=1. Combinationally pc_override=1 and int_pc=ret_reg. At the clock edge: in_service <= 0, state -> IDLE.
  - No interrupt can be taken in the return cycle, so at least one main-line instruction executes before re-entry.
  - reti without boundary is ignored.
- Outputs outside take/return cycles: pc_override=0 and int_pc=0.
- A mask change during SERVICE does not affect the current service.

Optional Feature:
- Macro: INT_SEQ_NESTED_EN.
- When defined:
  - Adds state SERVICE2 and a second return register.
  - In SERVICE, if boundary=1 and some eligible source has an index strictly lower than the in-service ID, it preempts: ret2 <= pc_next, that source's vector is driven, and in_service shows the new source only.
  - Nesting is limited to two levels; SERVICE2 cannot be preempted.
  - reti in SERVICE2 restores ret2 and the previous in_service value, then returns to SERVICE.
- When not defined: no preemption; behaviour is exactly as above.

Test Plan:
1. Basic take and return:
   - Stimulus: after reset, mask=0001; pulse irq[0]; next cycle boundary=1 with pc_next=10'h025.
   - Expect: pc_override=1, int_pc=10'h3C0, then in_service=0001.
   - Then reti+boundary. Expect: int_pc=10'h025, in_service=0000, state IDLE.
2. Priority order:
   - Stimulus: irq[1] and irq[3] rise together, mask=1111.
   - Expect: first boundary -> int_pc=10'h3C4 and pending=1000.
   - After reti, the next boundary -> int_pc=10'h3CC.
3. Masking:
   - Stimulus: mask=0000, pulse irq[2], several boundaries.
   - Expect: pending=0100 and pc_override stays 0.
   - Then write mask=0100. Expect: the next boundary takes 10'h3C8.
4. Held request and re-entry:
   - Stimulus: irq[0] held high for 20 cycles.
   - Expect: pending set once; after reti, no re-entry.
   - Stimulus: reti in IDLE. Expect: pc_override=0.
5. Reset during service:
   - Stimulus: reset during SERVICE with pending=0110.
   - Expect: next cycle pending=0, mask=0, in_service=0; a boundary gives pc_override=0.
6. Nesting (with INT_SEQ_NESTED_EN):
   - Stimulus: while servicing id2, irq[0] rises; boundary with pc_next=10'h3D0.
   - Expect: int_pc=10'h3C0.
   - First reti: int_pc=10'h3D0 and in_service=0100. Second reti: the original main-line address.

Source files
------------

// File: rtl/int_sequencer_if.sv
// int_sequencer_if: request, mask and PC-path signals between the core and int_sequencer
interface int_sequencer_if #(parameter int PCW = 10);
    logic [3:0] irq;
    logic mask_we;
    logic [3:0] mask_d;
    logic boundary;
    logic [PCW-1:0] pc_next;
    logic reti;
    logic pc_override;
    logic [PCW-1:0] int_pc;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic int_active;
    modport master(
        output irq, mask_we, mask_d, boundary, pc_next, reti,
        input pc_override, int_pc, pending, in_service, int_active
    );
    modport slave(
        input irq, mask_we, mask_d, boundary, pc_next, reti,
        output pc_override, int_pc, pending, in_service, int_active
    );
endinterface

// File: rtl/int_sequencer.sv
// int_sequencer: edge-latched masked priority interrupt PC sequencer; INT_SEQ_NESTED_EN adds one preemption level
module int_sequencer #(
    parameter int PCW = 10,
    parameter logic [PCW-1:0] VEC_BASE = PCW'(10'h3C0),
    parameter int VEC_SHIFT = 2
) (
    input logic clk,
    input logic reset,
    int_sequencer_if.slave bus
);
`ifdef INT_SEQ_NESTED_EN
    typedef enum logic [1:0] {IDLE, SERVICE, SERVICE2} state_t;
`else
    typedef enum logic [1:0] {IDLE, SERVICE} state_t;
`endif
    state_t state, state_n;
    logic [3:0] irq_q, pending, mask, in_service, eligible, rise, onehot;
    logic [1:0] id;
    logic [PCW-1:0] ret_reg, ret_pc, vec;
    logic take, back;
`ifdef INT_SEQ_NESTED_EN
    logic [PCW-1:0] ret2;
    logic [3:0] prev_service;
    assign ret_pc = state == SERVICE2 ? ret2 : ret_reg;
`else
    assign ret_pc = ret_reg;
`endif
    assign rise = bus.irq & ~irq_q;
    assign eligible = pending & mask;
    assign onehot = 4'b1 << id;
    assign vec = VEC_BASE + (PCW'(id) << VEC_SHIFT);
    always_comb begin
        id = 2'd0;
        for (int i = 3; i >= 0; i--) if (eligible[i]) id = 2'(i);
    end
    always_comb begin
        take = 1'b0;
        back = 1'b0;
        state_n = state;
        case (state)
            IDLE: begin
                take = bus.boundary && |eligible;
                state_n = take ? SERVICE : IDLE;
            end
            SERVICE: begin
                back = bus.boundary && bus.reti;
`ifdef INT_SEQ_NESTED_EN
                // eligible bits below the one-hot in-service bit are strictly higher priority
                take = bus.boundary && !bus.reti && |(eligible & (in_service - 4'd1));
                state_n = back ? IDLE : take ? SERVICE2 : SERVICE;
`else
                state_n = back ? IDLE : SERVICE;
`endif
            end
`ifdef INT_SEQ_NESTED_EN
            SERVICE2: begin
                back = bus.boundary && bus.reti;
                state_n = back ? SERVICE : SERVICE2;
            end
`endif
            default: state_n = IDLE;
        endcase
        bus.pc_override = take || back;
        bus.int_pc = take ? vec : back ? ret_pc : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            irq_q <= '0;
            pending <= '0;
            mask <= '0;
            in_service <= '0;
            ret_reg <= '0;
`ifdef INT_SEQ_NESTED_EN
            ret2 <= '0;
            prev_service <= '0;
`endif
        end else begin
            state <= state_n;
            irq_q <= bus.irq;
            if (bus.mask_we) mask <= bus.mask_d;
            // a fresh edge on the source being taken wins over its clear
            pending <= (pending & ~(take ? onehot : 4'b0)) | rise;
            if (take && state == IDLE) ret_reg <= bus.pc_next;
`ifdef INT_SEQ_NESTED_EN
            if (take && state == SERVICE) begin
                ret2 <= bus.pc_next;
                prev_service <= in_service;
            end
            in_service <= take ? onehot : back ? (state == SERVICE2 ? prev_service : 4'b0) : in_service;
`else
            in_service <= take ? onehot : back ? 4'b0 : in_service;
`endif
        end
    end
    assign bus.pending = pending;
    assign bus.in_service = in_service;
    assign bus.int_active = state != IDLE;
endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: scoreboard bench with a return-stack reference model of the interrupt sequencer
module tb_int_sequencer;
    localparam logic [9:0] VB = 10'h3C0;
`ifdef INT_SEQ_NESTED_EN
    localparam bit NESTED = 1'b1;
`else
    localparam bit NESTED = 1'b0;
`endif
    typedef struct {
        logic ovr;
        logic [9:0] pc;
        logic [3:0] pend;
        logic [3:0] insv;
        logic act;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    exp_t q[$];
    logic [3:0] m_pend = '0, m_mask = '0, m_prev = '0;
    int stk_id[$];
    logic [9:0] stk_pc[$];
    bit armed = 1'b0;
    int_sequencer_if #(.PCW(10)) bus ();
    int_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 4;
    endfunction
    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask
    task automatic step(input logic rs, input logic [3:0] irq, input logic mwe, input logic [3:0] md,
                        input logic bd, input logic [9:0] pcn, input logic rt);
        exp_t e;
        int tid;
        logic ret;
        @(posedge clk);
        #1;
        reset = rs;
        bus.irq = irq;
        bus.mask_we = mwe;
        bus.mask_d = md;
        bus.boundary = bd;
        bus.pc_next = pcn;
        bus.reti = rt;
        tid = -1;
        ret = 1'b0;
        if (stk_id.size() == 0) begin
            if (bd && lowest(m_pend & m_mask) < 4) tid = lowest(m_pend & m_mask);
        end else if (bd && rt) ret = 1'b1;
        else if (NESTED && stk_id.size() == 1 && bd && lowest(m_pend & m_mask) < stk_id[$])
            tid = lowest(m_pend & m_mask);
        e.ovr = tid >= 0 || ret;
        e.pc = tid >= 0 ? VB + 10'(tid * 4) : ret ? stk_pc[$] : 10'h0;
        e.pend = m_pend;
        e.insv = stk_id.size() == 0 ? 4'b0 : 4'(1 << stk_id[$]);
        e.act = stk_id.size() != 0;
        if (armed) q.push_back(e);
        if (rs) begin
            m_pend = '0;
            m_mask = '0;
            m_prev = '0;
            stk_id.delete();
            stk_pc.delete();
            armed = 1'b1;
        end else begin
            if (tid >= 0) begin
                stk_id.push_back(tid);
                stk_pc.push_back(pcn);
                m_pend[tid] = 1'b0;
            end
            if (ret) begin
                void'(stk_id.pop_back());
                void'(stk_pc.pop_back());
            end
            m_pend = m_pend | (irq & ~m_prev);
            m_prev = irq;
            if (mwe) m_mask = md;
        end
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_override", 10'(bus.pc_override), 10'(e.ovr));
            chk("int_pc", bus.int_pc, e.pc);
            chk("pending", 10'(bus.pending), 10'(e.pend));
            chk("in_service", 10'(bus.in_service), 10'(e.insv));
            chk("int_active", 10'(bus.int_active), 10'(e.act));
        end
    end
    initial begin
        logic [3:0] cur;
        logic rs, bd;
        bus.irq = '0;
        bus.mask_we = 1'b0;
        bus.mask_d = '0;
        bus.boundary = 1'b0;
        bus.pc_next = '0;
        bus.reti = 1'b0;
        step(1, 4'b0000, 0, 4'b0000, 0, 10'h000, 0);
        step(1, 4'b0000, 0, 4'b0000, 0, 10'h000, 0);
        step(0, 4'b0000, 1, 4'b0001, 0, 10'h000, 0);
        step(0, 4'b0001, 0, 4'b0000, 0, 10'h000, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h025, 0);
        step(0, 4'b0000, 0, 4'b0000, 0, 10'h026, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h027, 1);
        step(0, 4'b0000, 1, 4'b1111, 0, 10'h030, 0);
        step(0, 4'b1010, 0, 4'b0000, 0, 10'h031, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h032, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h100, 1);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h033, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h101, 1);
        step(0, 4'b0000, 1, 4'b0000, 0, 10'h040, 0);
        step(0, 4'b0100, 0, 4'b0000, 0, 10'h041, 0);
        for (int i = 0; i < 4; i++) step(0, 4'b0000, 0, 4'b0000, 1, 10'(10'h042 + i), 0);
        step(0, 4'b0000, 1, 4'b0100, 0, 10'h050, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h051, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h200, 1);
        step(0, 4'b0000, 1, 4'b1111, 0, 10'h060, 0);
        for (int i = 0; i < 20; i++) step(0, 4'b0001, 0, 4'b0000, i % 3 == 1, 10'(10'h061 + i), i == 7);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h080, 1);
        step(0, 4'b0000, 0, 4'b0000, 0, 10'h081, 1);
        step(0, 4'b0001, 0, 4'b0000, 0, 10'h090, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h091, 0);
        step(0, 4'b0110, 0, 4'b0000, 0, 10'h092, 0);
        step(0, 4'b0000, 0, 4'b0000, 0, 10'h093, 0);
        step(1, 4'b0000, 0, 4'b0000, 0, 10'h094, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h095, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h096, 0);
        step(0, 4'b0000, 1, 4'b1111, 0, 10'h0A0, 0);
        step(0, 4'b0100, 0, 4'b0000, 0, 10'h0A1, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h111, 0);
        step(0, 4'b0001, 0, 4'b0000, 0, 10'h3C9, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h3D0, 0);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h3C1, 1);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h3D1, 1);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h3D2, 1);
        step(0, 4'b0000, 0, 4'b0000, 1, 10'h112, 1);
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) cur[b] = ~cur[b];
            rs = $urandom_range(299) == 0;
            bd = !rs && $urandom_range(2) == 0;
            step(rs, cur, $urandom_range(19) == 0, 4'($urandom), bd, 10'($urandom), $urandom_range(2) == 0);
        end
        step(0, 4'b0000, 0, 4'b0000, 0, 10'h000, 0);
        repeat (3) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
